// File: rtl/axi4_lite_ctrl_master.sv
// AXI4-Lite initiator for the GPU control port.
// A single-entry command is turned into one AXI4-Lite read or write. The
// completed transaction comes back as a response carrying read data and
// RRESP/BRESP. Only one transaction is in flight at a time.
//
// Handshake rule for every channel here (cmd, rsp, AW, W, B, AR, R): a beat
// transfers on the rising edge where valid && ready. A valid never depends
// combinationally on its ready. Once raised, a valid and its payload hold
// steady until that transfer edge.
module axi4_lite_ctrl_master #(
    parameter int AXI_ADDRESS_WIDTH = 32,
    parameter int AXI_DATA_WIDTH    = 32
) (
    input  logic                          m_axi_ctrl_aclk,
    input  logic                          m_axi_ctrl_aresetn,
    // command side
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
    // response side
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,
    // write address channel
    output logic [AXI_ADDRESS_WIDTH-1:0]  m_axi_ctrl_awaddr,
    output logic                          m_axi_ctrl_awvalid,
    input  logic                          m_axi_ctrl_awready,
    // write data channel
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_ctrl_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_ctrl_wstrb,
    output logic                          m_axi_ctrl_wvalid,
    input  logic                          m_axi_ctrl_wready,
    // write response channel
    input  logic [1:0]                    m_axi_ctrl_bresp,
    input  logic                          m_axi_ctrl_bvalid,
    output logic                          m_axi_ctrl_bready,
    // read address channel
    output logic [AXI_ADDRESS_WIDTH-1:0]  m_axi_ctrl_araddr,
    output logic                          m_axi_ctrl_arvalid,
    input  logic                          m_axi_ctrl_arready,
    // read data channel
    input  logic [AXI_DATA_WIDTH-1:0]     m_axi_ctrl_rdata,
    input  logic [1:0]                    m_axi_ctrl_rresp,
    input  logic                          m_axi_ctrl_rvalid,
    output logic                          m_axi_ctrl_rready,
    // FSM state for debug and checkers
    output logic [2:0]                    dbg_state
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t                         state_q, state_d;
    logic [AXI_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [STRB_W-1:0]              wstrb_q, wstrb_d;
    logic                           arvalid_q, arvalid_d;
    logic                           rready_q, rready_d;
    logic                           awvalid_q, awvalid_d;
    logic                           wvalid_q, wvalid_d;
    logic                           bready_q, bready_d;
    logic                           aw_done_q, aw_done_d;
    logic                           w_done_q, w_done_d;
    logic                           rsp_valid_q, rsp_valid_d;
    logic [AXI_DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                     rsp_resp_q, rsp_resp_d;
    logic                           aw_hs;
    logic                           w_hs;

    // The only unregistered output: the command slot is open in IDLE and out of reset.
    assign cmd_ready = (state_q == IDLE) && m_axi_ctrl_aresetn;

    assign aw_hs = awvalid_q && m_axi_ctrl_awready;
    assign w_hs  = wvalid_q && m_axi_ctrl_wready;

    // Next-state and next-output logic. Every register holds its value unless a case below changes it.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    if (cmd_write) begin
                        wstrb_d   = '1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (m_axi_ctrl_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi_ctrl_rvalid) begin
                    rsp_rdata_d = m_axi_ctrl_rdata;
                    rsp_resp_d  = m_axi_ctrl_rresp;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            WR_REQ: begin
                // AW and W finish independently; the done flags remember whichever finished first.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_ctrl_bvalid) begin
                    rsp_resp_d  = m_axi_ctrl_bresp;
                    rsp_rdata_d = '0;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers. Reset abandons any transaction in flight.
    always_ff @(posedge m_axi_ctrl_aclk or negedge m_axi_ctrl_aresetn) begin
        if (!m_axi_ctrl_aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign m_axi_ctrl_awaddr  = addr_q;
    assign m_axi_ctrl_araddr  = addr_q;
    assign m_axi_ctrl_wdata   = wdata_q;
    assign m_axi_ctrl_wstrb   = wstrb_q;
    assign m_axi_ctrl_arvalid = arvalid_q;
    assign m_axi_ctrl_rready  = rready_q;
    assign m_axi_ctrl_awvalid = awvalid_q;
    assign m_axi_ctrl_wvalid  = wvalid_q;
    assign m_axi_ctrl_bready  = bready_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_rdata          = rsp_rdata_q;
    assign rsp_resp           = rsp_resp_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_axi4_lite_ctrl_master.sv
// Directed bench for axi4_lite_ctrl_master. The bench plays the command source,
// the response sink and a cycle-stepped AXI4-Lite slave. It drives and samples
// on the falling clock edge.
module tb_axi4_lite_ctrl_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [2:0]  dbg_state;

    int          n_vec;
    int          n_err;
    logic [33:0] exp_q[$];
    logic [31:0] mem [logic [31:0]];

    axi4_lite_ctrl_master #(
        .AXI_ADDRESS_WIDTH(32),
        .AXI_DATA_WIDTH   (32)
    ) dut (
        .m_axi_ctrl_aclk   (clk),
        .m_axi_ctrl_aresetn(rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_wdata         (cmd_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rdata         (rsp_rdata),
        .rsp_resp          (rsp_resp),
        .m_axi_ctrl_awaddr (awaddr),
        .m_axi_ctrl_awvalid(awvalid),
        .m_axi_ctrl_awready(awready),
        .m_axi_ctrl_wdata  (wdata),
        .m_axi_ctrl_wstrb  (wstrb),
        .m_axi_ctrl_wvalid (wvalid),
        .m_axi_ctrl_wready (wready),
        .m_axi_ctrl_bresp  (bresp),
        .m_axi_ctrl_bvalid (bvalid),
        .m_axi_ctrl_bready (bready),
        .m_axi_ctrl_araddr (araddr),
        .m_axi_ctrl_arvalid(arvalid),
        .m_axi_ctrl_arready(arready),
        .m_axi_ctrl_rdata  (rdata),
        .m_axi_ctrl_rresp  (rresp),
        .m_axi_ctrl_rvalid (rvalid),
        .m_axi_ctrl_rready (rready),
        .dbg_state         (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so that a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Check the held response against the scoreboard, optionally stall it, then consume it.
    task automatic finish_rsp(input int hold);
        logic [33:0] exp;
        chk("sb_not_empty", 64'(exp_q.size() > 0), 64'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h0;
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp[31:0]));
        chk("rsp_resp", 64'(rsp_resp), 64'(exp[33:32]));
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            @(negedge clk);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(exp[31:0]));
            chk("hold_rsp_resp", 64'(rsp_resp), 64'(exp[33:32]));
            chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("hold_no_axi", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        chk("cmd_ready_back", 64'(cmd_ready), 64'd1);
        chk("state_idle", 64'(dbg_state), 64'd0);
    endtask

    // Read: AR accepted after ar_wait stall cycles, then one R beat.
    task automatic do_read(input logic [31:0] addr, input int ar_wait, input logic [31:0] slv_rdata,
                           input logic [1:0] slv_rresp, input logic [31:0] exp_rdata, input int hold);
        exp_q.push_back({slv_rresp, exp_rdata});
        chk("rd_cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = addr;
        cmd_wdata = 32'hcafe_0000;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c <= ar_wait; c++) begin
            chk("rd_busy_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("arvalid_high", 64'(arvalid), 64'd1);
            chk("araddr", 64'(araddr), 64'(addr));
            chk("rready_early", 64'(rready), 64'd0);
            chk("rd_no_aw", 64'({awvalid, wvalid}), 64'd0);
            arready = (c == ar_wait);
            @(negedge clk);
        end
        arready = 1'b0;
        chk("arvalid_drop", 64'(arvalid), 64'd0);
        chk("rready_high", 64'(rready), 64'd1);
        chk("rsp_valid_early", 64'(rsp_valid), 64'd0);
        rvalid = 1'b1;
        rdata  = slv_rdata;
        rresp  = slv_rresp;
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = 32'h0;
        rresp  = 2'b00;
        chk("rready_drop", 64'(rready), 64'd0);
        finish_rsp(hold);
    endtask

    // Write: AW accepted after aw_wait stalls, W after w_wait stalls, then one B beat.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int aw_wait,
                            input int w_wait, input logic [1:0] slv_bresp, input int hold);
        int          last;
        logic [31:0] cap_aw;
        logic [31:0] cap_w;
        cap_aw = 32'h0;
        cap_w  = 32'h0;
        last = (aw_wait > w_wait) ? aw_wait : w_wait;
        exp_q.push_back({slv_bresp, 32'h0});
        chk("wr_cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = addr;
        cmd_wdata = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        for (int c = 0; c <= last; c++) begin
            chk("wr_busy_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("awvalid", 64'(awvalid), 64'(c <= aw_wait));
            chk("wvalid", 64'(wvalid), 64'(c <= w_wait));
            chk("bready_early", 64'(bready), 64'd0);
            chk("wr_no_ar", 64'(arvalid), 64'd0);
            if (c <= aw_wait) chk("awaddr", 64'(awaddr), 64'(addr));
            if (c <= w_wait) begin
                chk("wdata", 64'(wdata), 64'(data));
                chk("wstrb", 64'(wstrb), 64'hf);
            end
            awready = (c == aw_wait);
            wready  = (c == w_wait);
            if (c == aw_wait) cap_aw = awaddr;
            if (c == w_wait) cap_w = wdata;
            @(negedge clk);
        end
        awready = 1'b0;
        wready  = 1'b0;
        mem[cap_aw] = cap_w;
        chk("aw_w_drop", 64'({awvalid, wvalid}), 64'd0);
        chk("bready_high", 64'(bready), 64'd1);
        chk("wr_rsp_valid_early", 64'(rsp_valid), 64'd0);
        bvalid = 1'b1;
        bresp  = slv_bresp;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
        chk("bready_drop", 64'(bready), 64'd0);
        finish_rsp(hold);
    endtask

    // Stimulus
    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bresp     = 2'b00;
        bvalid    = 1'b0;
        arready   = 1'b0;
        rdata     = 32'h0;
        rresp     = 2'b00;
        rvalid    = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready, rsp_valid}), 64'd0);
        chk("rst_addr", 64'({awaddr, araddr}), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_rsp", 64'({rsp_rdata, rsp_resp}), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Stray R/B beats in IDLE are not taken.
        rvalid = 1'b1;
        bvalid = 1'b1;
        rdata  = 32'h1111_2222;
        @(negedge clk);
        chk("stray_ready", 64'({rready, bready}), 64'd0);
        chk("stray_rsp", 64'(rsp_valid), 64'd0);
        chk("stray_state", 64'(dbg_state), 64'd0);
        rvalid = 1'b0;
        bvalid = 1'b0;
        rdata  = 32'h0;

        // 1: read 0x01, arready after one stall, OKAY all-ones data
        do_read(32'h1, 1, 32'hffff_ffff, 2'b00, 32'hffff_ffff, 0);
        // 2: write 0x01/0x01, AW at once, W three cycles later
        do_write(32'h1, 32'h1, 0, 3, 2'b00, 0);
        // 3: SLVERR read passed through
        do_read(32'h20, 0, 32'hdead_beef, 2'b10, 32'hdead_beef, 0);
        // 4: response held five cycles, new command waiting meanwhile
        do_read(32'h30, 0, 32'h0bad_f00d, 2'b00, 32'h0bad_f00d, 5);
        // W before AW, DECERR write response
        do_write(32'h40, 32'h1234_5678, 2, 0, 2'b11, 1);
        // 5: back-to-back write then read of the same register
        do_write(32'h4, 32'ha5, 0, 0, 2'b00, 0);
        do_read(32'h4, 0, mem[32'h4], 2'b00, 32'ha5, 0);

        // 6: reset while AW is stalled
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h8;
        cmd_wdata = 32'h55;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        chk("mid_awvalid", 64'(awvalid), 64'd1);
        @(negedge clk);
        chk("mid_awvalid_held", 64'(awvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready, rsp_valid}), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("mid_rst_addr", 64'(awaddr), 64'd0);
        chk("mid_rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        do_read(32'h10, 0, 32'h1234_5678, 2'b00, 32'h1234_5678, 0);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
